prog_boot_loader: RTL and testbench
===================================

Name: prog_boot_loader

Overview:
- Parameterised boot sequencer for the Harvard CPU.
- Accepts a length-prefixed word stream over a valid/ready handshake and writes it into program memory through that memory's write port.
- Holds the CPU in reset during loading and for a programmable settle period afterwards, then releases it.
- Replaces the fixed clock-only bring-up: simulation and FPGA boot share one loader, generalised in word width and program depth.

Parameters:
- DATA_W, 8, width of stream words and program memory words.
- ADDR_W, 8, program memory address width.
- DEPTH, 256, number of usable program words; must be no greater than 2**ADDR_W.
- HOLD_CYC, 4, cycles cpu_rst_n stays low after the last write; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin or restart a load.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word; the first word of a load is the length header.
- in_ready  out  1  loader accepts in_data this cycle.
- prog_we  out  1  program memory write enable.
- prog_waddr  out  ADDR_W  program memory write address.
- prog_wdata  out  DATA_W  program memory write data.
- cpu_rst_n  out  1  active-low reset to the CPU core.
- busy  out  1  load in progress (HDR, LOAD or HOLD).
- done  out  1  program loaded and CPU running.
- err  out  1  sticky: last header exceeded DEPTH.

Behaviour:
- Reset (async assert, sync deassert on clk): state IDLE.
  - All outputs 0, including cpu_rst_n = 0.
  - Word counter = 0 and hold counter = 0.
- Acceptance: a word is accepted only on a clk edge where in_valid and in_ready are both 1.
- Handshake: in_valid is ignored whenever in_ready = 0. in_ready is 1 only in HDR and LOAD and is driven from state alone, with no combinational path from in_valid.
- All outputs are registered.
- IDLE:
  - start goes to HDR; err clears on that same edge.
  - cpu_rst_n stays 0.
- HDR:
  - On acceptance, len = in_data.
  - If len > DEPTH: err = 1, go to IDLE, cpu_rst_n stays 0.
  - If len = 0: go to HOLD.
  - Otherwise go to LOAD with counter = 0.
- LOAD:
  - Each accepted word produces, on the next cycle, prog_we = 1, prog_waddr = counter and prog_wdata = the word. Write latency is 1 cycle.
  - The counter increments per accepted word.
  - On acceptance when counter = len-1, go to HOLD; in_ready drops on the next cycle.
  - Cycles with no acceptance (bubbles) produce prog_we = 0. prog_waddr and prog_wdata hold their previous values.
- HOLD:
  - cpu_rst_n = 0.
  - The hold counter counts HOLD_CYC cycles, then the state goes to RUN.
  - The last prog_we pulse occurs in the first HOLD cycle.
- RUN:
  - cpu_rst_n = 1, done = 1, busy = 0.
  - start goes to HDR: on the next cycle cpu_rst_n = 0 and done = 0 (reload).
- busy = 1 exactly in HDR, LOAD and HOLD.
- start while busy is ignored.
- Address arithmetic: the counter is ADDR_W+1 bits wide so that len = DEPTH = 2**ADDR_W does not wrap. prog_waddr is the lower ADDR_W bits.
- rst_n asserted mid-load aborts immediately:
  - prog_we = 0 and cpu_rst_n = 0.
  - Partially written memory is left as is.
  - A fresh start is required.

Decomposition:
- Shared package cpu_boot_pkg holds:
  - the state encoding enum (IDLE, HDR, LOAD, HOLD, RUN);
  - the default DATA_W and ADDR_W constants shared with the CPU and memories.
- One natural sub-module, rst_hold_counter: a loadable down-counter with a terminal flag, parameterised by HOLD_CYC, reused for the CPU reset stretch.

Test Plan:
- Basic load: start; stream 3, 0xA1, 0xB2, 0xC3 with in_valid held 1 -> writes (0,A1), (1,B2), (2,C3) on consecutive cycles; cpu_rst_n rises 4 cycles after the last write cycle; done = 1, busy = 0.
- Bubbles: same stream with in_valid deasserted for 2 cycles between each word -> same three writes, prog_we = 0 during the gaps, addresses contiguous.
- Zero length: start; header 0 -> no prog_we pulse; HOLD lasts 4 cycles; cpu_rst_n = 1.
- Oversize header: DEPTH = 16; header 17 -> err = 1, state IDLE, cpu_rst_n = 0, no writes; then start clears err.
- Reload from RUN: after a complete load, start; header 1, 0x5E -> cpu_rst_n = 0 and done = 0 on the next cycle, write (0,5E), then release again after HOLD_CYC cycles.
- Reset mid-load: assert rst_n low after 2 of 5 data words -> prog_we = 0, in_ready = 0 and cpu_rst_n = 0 immediately (asynchronously); after release, state IDLE and start is required; start is ignored during busy in a separate check.

Source files
------------

// File: rtl/cpu_boot_pkg.sv
// Shared boot-sequencer definitions: loader state encoding and the default
// word/address widths used by the CPU, its memories and the boot loader.
package cpu_boot_pkg;

   localparam int unsigned BOOT_DATA_W = 8;
   localparam int unsigned BOOT_ADDR_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
      S_HOLD,
      S_RUN
   } boot_state_t;

endpackage

// File: rtl/rst_hold_counter.sv
// Loadable down-counter used to stretch the CPU reset. Loading arms it for
// HOLD_CYC cycles; term is high once the count has reached zero.
module rst_hold_counter #(
   parameter int unsigned HOLD_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic term
);

   localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYC - 1);

   logic [CNT_W-1:0] count;

   // Load on entry to the hold window, then count down to zero and stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign term = (count == '0);

endmodule

// File: rtl/prog_boot_loader.sv
// Boot sequencer: takes a length-prefixed word stream over valid/ready,
// writes it into program memory and keeps the CPU in reset until the load
// and a HOLD_CYC settle period are complete.
module prog_boot_loader
   import cpu_boot_pkg::*;
#(
   parameter int unsigned DATA_W   = BOOT_DATA_W,
   parameter int unsigned ADDR_W   = BOOT_ADDR_W,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned HOLD_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              prog_we,
   output logic [ADDR_W-1:0] prog_waddr,
   output logic [DATA_W-1:0] prog_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Wide enough to hold any header value and the full word count
   // (len = DEPTH = 2**ADDR_W) without wrapping.
   localparam int unsigned     LEN_W   = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   boot_state_t       state, state_d;
   logic [ADDR_W:0]   cnt, cnt_d;
   logic [LEN_W-1:0]  len, len_d;
   logic [LEN_W-1:0]  hdr_len;
   logic [LEN_W-1:0]  cnt_next_ext;
   logic              err_d;
   logic              we_d;
   logic [ADDR_W-1:0] waddr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              accept;
   logic              hold_load;
   logic              hold_term;

   assign accept       = in_valid & in_ready;
   assign hdr_len      = LEN_W'(in_data);
   assign cnt_next_ext = LEN_W'(cnt) + LEN_W'(1);
   assign hold_load    = (state_d == S_HOLD) && (state != S_HOLD);

   rst_hold_counter #(
      .HOLD_CYC (HOLD_CYC)
   ) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (hold_load),
      .en    (state == S_HOLD),
      .term  (hold_term)
   );

   // Next-state and next-output decode for the boot sequence.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      len_d   = len;
      err_d   = err;
      we_d    = 1'b0;
      waddr_d = prog_waddr;
      wdata_d = prog_wdata;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               err_d   = 1'b0;
            end
         end
         S_HDR: begin
            if (accept) begin
               len_d = hdr_len;
               cnt_d = '0;
               if (hdr_len > DEPTH_L) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (hdr_len == '0) begin
                  state_d = S_HOLD;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               waddr_d = cnt[ADDR_W-1:0];
               wdata_d = in_data;
               cnt_d   = cnt + (ADDR_W+1)'(1);
               if (cnt_next_ext == len) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (hold_term) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (start) begin
               state_d = S_HDR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register and load bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         len   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         len   <= len_d;
      end
   end

   // Outputs are registered; status flags are decoded from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready   <= 1'b0;
         prog_we    <= 1'b0;
         prog_waddr <= '0;
         prog_wdata <= '0;
         cpu_rst_n  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         in_ready   <= (state_d == S_HDR) || (state_d == S_LOAD);
         prog_we    <= we_d;
         prog_waddr <= waddr_d;
         prog_wdata <= wdata_d;
         cpu_rst_n  <= (state_d == S_RUN);
         busy       <= (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_HOLD);
         done       <= (state_d == S_RUN);
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_boot_loader.sv
// Directed bench for prog_boot_loader with a 16-word program space.
module tb_prog_boot_loader;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned HOLD_CYC = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_waddr;
   logic [DATA_W-1:0] prog_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   int n_tests = 0;
   int n_fail  = 0;

   prog_boot_loader #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .prog_we    (prog_we),
      .prog_waddr (prog_waddr),
      .prog_wdata (prog_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
      chk({tag, "_we"},    32'(prog_we),    32'h1);
      chk({tag, "_waddr"}, 32'(prog_waddr), addr);
      chk({tag, "_wdata"}, 32'(prog_wdata), data);
   endtask

   // n_low more cycles in HOLD with the CPU held, then release into RUN.
   task automatic do_hold(input string tag, input int n_low);
      for (int k = 0; k < n_low; k++) begin
         tick;
         chk({tag, "_hold_cpu"}, 32'(cpu_rst_n), 32'h0);
         chk({tag, "_hold_we"},  32'(prog_we),   32'h0);
         chk({tag, "_hold_busy"}, 32'(busy),     32'h1);
      end
      tick;
      chk({tag, "_run_cpu"},  32'(cpu_rst_n), 32'h1);
      chk({tag, "_run_done"}, 32'(done),      32'h1);
      chk({tag, "_run_busy"}, 32'(busy),      32'h0);
      chk({tag, "_run_rdy"},  32'(in_ready),  32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w3 [3];
      w3[0] = 8'hA1;
      w3[1] = 8'hB2;
      w3[2] = 8'hC3;

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick;
      tick;
      chk("rst_ready", 32'(in_ready),   32'h0);
      chk("rst_we",    32'(prog_we),    32'h0);
      chk("rst_waddr", 32'(prog_waddr), 32'h0);
      chk("rst_wdata", 32'(prog_wdata), 32'h0);
      chk("rst_cpu",   32'(cpu_rst_n),  32'h0);
      chk("rst_busy",  32'(busy),       32'h0);
      chk("rst_done",  32'(done),       32'h0);
      chk("rst_err",   32'(err),        32'h0);
      rst_n = 1'b1;
      tick;
      chk("idle_ready", 32'(in_ready), 32'h0);

      // Basic load: 3, A1, B2, C3 back to back
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("b_hdr_rdy",  32'(in_ready),  32'h1);
      chk("b_hdr_busy", 32'(busy),      32'h1);
      chk("b_hdr_cpu",  32'(cpu_rst_n), 32'h0);
      in_valid = 1'b1;
      in_data  = 8'd3;
      tick;
      chk("b_len_we", 32'(prog_we), 32'h0);
      for (int i = 0; i < 3; i++) begin
         in_data = w3[i];
         tick;
         chk_wr("b_w", 32'(i), 32'(w3[i]));
      end
      chk("b_last_rdy", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      do_hold("b", 3);

      // Reload from RUN with bubbles between words
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("r_cpu",  32'(cpu_rst_n), 32'h0);
      chk("r_done", 32'(done),      32'h0);
      chk("r_busy", 32'(busy),      32'h1);
      in_valid = 1'b1;
      in_data  = 8'd3;
      tick;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = w3[i];
         tick;
         chk_wr("g_w", 32'(i), 32'(w3[i]));
         if (i < 2) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
            for (int k = 0; k < 2; k++) begin
               tick;
               chk("g_gap_we",    32'(prog_we),    32'h0);
               chk("g_gap_waddr", 32'(prog_waddr), 32'(i));
               chk("g_gap_wdata", 32'(prog_wdata), 32'(w3[i]));
            end
         end
      end
      chk("g_last_rdy", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      do_hold("g", 3);

      // Reload with a single word
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("s_cpu",  32'(cpu_rst_n), 32'h0);
      chk("s_done", 32'(done),      32'h0);
      in_valid = 1'b1;
      in_data  = 8'd1;
      tick;
      in_data = 8'h5E;
      tick;
      chk_wr("s_w", 32'h0, 32'h5E);
      chk("s_rdy", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      do_hold("s", 3);

      // Zero-length header: straight to a 4-cycle HOLD, no writes
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'd0;
      tick;
      in_valid = 1'b0;
      chk("z_we",   32'(prog_we),   32'h0);
      chk("z_rdy",  32'(in_ready),  32'h0);
      chk("z_busy", 32'(busy),      32'h1);
      chk("z_cpu",  32'(cpu_rst_n), 32'h0);
      do_hold("z", 3);

      // Oversize header (17 > 16): error, back to IDLE
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'd17;
      tick;
      in_valid = 1'b0;
      chk("o_err",  32'(err),       32'h1);
      chk("o_busy", 32'(busy),      32'h0);
      chk("o_rdy",  32'(in_ready),  32'h0);
      chk("o_cpu",  32'(cpu_rst_n), 32'h0);
      chk("o_done", 32'(done),      32'h0);
      chk("o_we",   32'(prog_we),   32'h0);
      tick;
      chk("o_err_sticky", 32'(err), 32'h1);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("o_err_clr", 32'(err),      32'h0);
      chk("o_hdr_rdy", 32'(in_ready), 32'h1);

      // Full-depth header (16 = DEPTH): accepted, addresses 0..15
      in_valid = 1'b1;
      in_data  = 8'd16;
      tick;
      chk("f_err",  32'(err),  32'h0);
      chk("f_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(8'h30 + i);
         tick;
         chk_wr("f_w", 32'(i), 32'(8'h30 + i));
      end
      chk("f_last_rdy", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      do_hold("f", 3);

      // start while busy is ignored (during LOAD and HOLD)
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'd2;
      tick;
      in_data = 8'h11;
      start   = 1'b1;
      tick;
      chk_wr("i_w0", 32'h0, 32'h11);
      chk("i_rdy0", 32'(in_ready), 32'h1);
      start   = 1'b0;
      in_data = 8'h22;
      tick;
      chk_wr("i_w1", 32'h1, 32'h22);
      in_valid = 1'b0;
      start    = 1'b1;
      tick;
      start = 1'b0;
      chk("i_hold_cpu",  32'(cpu_rst_n), 32'h0);
      chk("i_hold_rdy",  32'(in_ready),  32'h0);
      chk("i_hold_busy", 32'(busy),      32'h1);
      do_hold("i", 2);

      // Asynchronous reset after 2 of 5 data words
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'd5;
      tick;
      in_data = 8'h61;
      tick;
      chk_wr("m_w0", 32'h0, 32'h61);
      in_data = 8'h62;
      tick;
      chk_wr("m_w1", 32'h1, 32'h62);
      #2;
      rst_n = 1'b0;
      #1;
      chk("m_async_we",   32'(prog_we),   32'h0);
      chk("m_async_rdy",  32'(in_ready),  32'h0);
      chk("m_async_cpu",  32'(cpu_rst_n), 32'h0);
      chk("m_async_busy", 32'(busy),      32'h0);
      in_data = 8'h63;
      tick;
      rst_n = 1'b1;
      tick;
      chk("m_idle_rdy",  32'(in_ready),  32'h0);
      chk("m_idle_busy", 32'(busy),      32'h0);
      chk("m_idle_we",   32'(prog_we),   32'h0);
      chk("m_idle_cpu",  32'(cpu_rst_n), 32'h0);
      chk("m_idle_done", 32'(done),      32'h0);
      in_valid = 1'b0;
      start    = 1'b1;
      tick;
      start = 1'b0;
      chk("m_restart_busy", 32'(busy),     32'h1);
      chk("m_restart_rdy",  32'(in_ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
